ota_cmp_sequencer: RTL and testbench
====================================

Name: ota_cmp_sequencer

Overview:
- Controller that sequences the digital OTA/comparator core.
- Enables the core, waits a settle interval, then takes an odd number of synchronized samples of the raw comparator output.
- Majority-votes the samples and hands the decision to a consumer over a valid/ready handshake.
- Sits between the OTA core (ota_en, cmp_out) and the user logic; supports one-shot requests and periodic auto-triggering.

Parameters:
- SETTLE_CYCLES, 4: cycles ota_en is high before sampling starts; must be >=1.
- NUM_SAMPLES, 5: samples taken per conversion; must be odd and >=1.
- PER_W, 8: width of the auto-trigger period counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle conversion request.
- auto_en  input  1  enables periodic triggering.
- auto_period  input  PER_W  trigger interval in cycles; 0 means no auto triggers.
- cmp_out  input  1  raw, asynchronous comparator output from the OTA core.
- ota_en  output  1  enable to the OTA core, registered.
- busy  output  1  high whenever state != IDLE.
- result  output  1  majority decision: 1 means Vip > Vin.
- result_valid  output  1  result is available.
- result_ready  input  1  consumer accepts the result.
- overrun  output  1  one-cycle pulse when a trigger is dropped.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - On rst, every register clears: state=IDLE, ota_en=0, busy=0, result=0, result_valid=0, overrun=0, counters=0, pending=0, synchronizer flops=0.
  - Reset asserted mid-conversion aborts the conversion. No result is produced.
- Synchronizer: cmp_out passes through a 2-flop synchronizer at all times. The synchronized value is cmp_s.
- FSM states: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE:
  - Outputs: ota_en=0, result_valid=0.
  - trigger = start | pending | auto_tick.
  - On trigger: go to SETTLE, set ota_en=1 from the next cycle, clear pending.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then goes to SAMPLE.
  - SETTLE_CYCLES absorbs synchronizer latency; the integrator must size it >= 2 plus the analog settle time.
- SAMPLE:
  - Each cycle, add cmp_s to a ones counter, for NUM_SAMPLES cycles.
  - On the last sample: result <= (ones + cmp_s) > NUM_SAMPLES/2, result_valid <= 1, ota_en <= 0, go to HOLD.
  - The ones counter is $clog2(NUM_SAMPLES+1) bits wide and never wraps.
- HOLD:
  - result and result_valid stay stable until result_ready=1.
  - On the handshake cycle, result_valid clears next cycle and the FSM returns to IDLE.
  - If start or pending is present in the handshake cycle, go directly to SETTLE (back-to-back conversion; ota_en rises next cycle).
- Latency: start high at cycle 0 (IDLE), ota_en high at cycles 1..S+N, result_valid high at cycle S+N+1 (cycle 10 for defaults).
- Auto-trigger:
  - While auto_en=1 and auto_period!=0, the period counter increments every cycle.
  - When it equals auto_period-1, it produces auto_tick for one cycle and reloads to 0.
  - auto_en=0 clears the counter and pending.
  - A change to auto_period takes effect on the next reload. If the counter is already >= the new value, it reloads immediately.
- Dropped triggers:
  - start while busy (except in a HOLD handshake cycle): dropped, overrun pulses.
  - auto_tick while busy: sets pending.
  - auto_tick while pending is already set: overrun pulses, pending stays 1.
  - start and auto_tick together in IDLE: one conversion, no pending, no overrun.
- busy is combinational from state. All other outputs are registered.

Decomposition:
- Package ota_ctrl_pkg:
  - FSM state encoding constants: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, HOLD=2'd3.
  - Helper function for majority threshold width.
- Sub-module cmp_sync: 2-flop synchronizer with synchronous active-high reset. It is reused by other blocks for the asynchronous OTA output.

Test Plan:
- Reset then idle: rst for 3 cycles, cmp_out=1 -> all outputs 0; ota_en never rises while no trigger.
- Basic conversion: start pulse at cycle 0, cmp_out=1 constant, result_ready=1 -> ota_en high cycles 1..9, result_valid=1 with result=1 at cycle 10, low at cycle 11.
- Majority filter: cmp_s pattern 1,0,1,0,0 across SAMPLE -> result=0. Pattern 1,1,0,0,1 -> result=1.
- Backpressure and back-to-back: result_ready=0 for 6 cycles -> result_valid and result held. Then result_ready=1 with start in the same cycle -> FSM goes to SETTLE, second result_valid appears 10 cycles later.
- Auto mode: auto_en=1, auto_period=20, result_ready=1 -> conversions start every 20 cycles, no overrun. auto_period=6 -> pending is serviced, overrun pulses on the second missed tick.
- Abort: rst asserted at cycle 7 of a conversion -> ota_en=0, state IDLE, no result_valid ever. A new start afterwards converts normally.

Source files
------------

// File: rtl/ota_ctrl_pkg.sv
// Shared types and sizing helpers for the OTA/comparator sequencer.
package ota_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Width that can hold a ones count from 0 up to num_samples without wrapping.
    function automatic int ones_width(input int num_samples);
        return $clog2(num_samples + 1);
    endfunction

    function automatic int count_width(input int settle_cycles, input int num_samples);
        int longest;
        longest = (settle_cycles > num_samples) ? settle_cycles : num_samples;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output of the OTA core.
module cmp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ota_cmp_sequencer.sv
// Sequences the OTA core: enable, settle, majority-sample the comparator,
// then hand the decision over valid/ready; supports one-shot and periodic triggers.
module ota_cmp_sequencer
    import ota_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_SAMPLES   = 5,
    parameter int PER_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             auto_en,
    input  logic [PER_W-1:0] auto_period,
    input  logic             cmp_out,
    output logic             ota_en,
    output logic             busy,
    output logic             result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun
);

    localparam int OW = ones_width(NUM_SAMPLES);
    localparam int CW = count_width(SETTLE_CYCLES, NUM_SAMPLES);
    localparam logic [OW-1:0] HALF       = OW'(NUM_SAMPLES / 2);
    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_END = CW'(NUM_SAMPLES - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [OW-1:0]    ones, ones_nx, ones_sum;
    logic [PER_W-1:0] per_cnt, per_cnt_nx;
    logic             ota_en_nx, result_nx, result_valid_nx, overrun_nx;
    logic             pending, pending_nx;
    logic             cmp_s, auto_tick, consume, drop_start, drop_tick;

    cmp_sync u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_out),
        .q   (cmp_s)
    );

    assign busy     = (state != IDLE);
    assign ones_sum = ones + OW'(cmp_s);

    // Period counter: a period change is honoured at the next reload, or at
    // once if the counter has already run past the new period.
    always_comb begin
        per_cnt_nx = per_cnt;
        auto_tick  = 1'b0;
        if (!auto_en) begin
            per_cnt_nx = '0;
        end else if (auto_period != '0) begin
            if (per_cnt == auto_period - PER_W'(1)) begin
                auto_tick  = 1'b1;
                per_cnt_nx = '0;
            end else if (per_cnt >= auto_period) begin
                per_cnt_nx = '0;
            end else begin
                per_cnt_nx = per_cnt + PER_W'(1);
            end
        end
    end

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        ones_nx         = ones;
        ota_en_nx       = ota_en;
        result_nx       = result;
        result_valid_nx = result_valid;
        consume         = 1'b0;
        drop_start      = 1'b0;

        case (state)
            IDLE: begin
                ota_en_nx       = 1'b0;
                result_valid_nx = 1'b0;
                if (start || pending || auto_tick) begin
                    state_nx  = SETTLE;
                    cnt_nx    = '0;
                    ones_nx   = '0;
                    ota_en_nx = 1'b1;
                    consume   = 1'b1;
                end
            end
            SETTLE: begin
                drop_start = start;
                if (cnt == SETTLE_END) begin
                    state_nx = SAMPLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            SAMPLE: begin
                drop_start = start;
                ones_nx    = ones_sum;
                if (cnt == SAMPLE_END) begin
                    result_nx       = (ones_sum > HALF);
                    result_valid_nx = 1'b1;
                    ota_en_nx       = 1'b0;
                    state_nx        = HOLD;
                    cnt_nx          = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (result_ready) begin
                    result_valid_nx = 1'b0;
                    if (start || pending) begin
                        state_nx  = SETTLE;
                        cnt_nx    = '0;
                        ones_nx   = '0;
                        ota_en_nx = 1'b1;
                        consume   = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    drop_start = start;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // One queued auto trigger is kept while busy; a second one is dropped.
    always_comb begin
        pending_nx = pending;
        drop_tick  = 1'b0;
        if (consume) begin
            pending_nx = 1'b0;
        end
        if (auto_tick && (state != IDLE)) begin
            if (pending && !consume) begin
                drop_tick = 1'b1;
            end else begin
                pending_nx = 1'b1;
            end
        end
        if (!auto_en) begin
            pending_nx = 1'b0;
        end
        overrun_nx = drop_start | drop_tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ones         <= '0;
            per_cnt      <= '0;
            pending      <= 1'b0;
            ota_en       <= 1'b0;
            result       <= 1'b0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            ones         <= ones_nx;
            per_cnt      <= per_cnt_nx;
            pending      <= pending_nx;
            ota_en       <= ota_en_nx;
            result       <= result_nx;
            result_valid <= result_valid_nx;
            overrun      <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_ota_cmp_sequencer.sv
// Self-checking bench for ota_cmp_sequencer: directed timelines with random
// comparator data, expected results derived from the recorded cmp_out history.
module tb_ota_cmp_sequencer;

    localparam int S     = 4;
    localparam int N     = 5;
    localparam int PER_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             auto_en;
    logic [PER_W-1:0] auto_period;
    logic             cmp_out;
    logic             result_ready;
    logic             ota_en;
    logic             busy;
    logic             result;
    logic             result_valid;
    logic             overrun;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic hist [0:4095];

    always #5 clk = ~clk;

    ota_cmp_sequencer #(
        .SETTLE_CYCLES (S),
        .NUM_SAMPLES   (N),
        .PER_W         (PER_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .auto_en      (auto_en),
        .auto_period  (auto_period),
        .cmp_out      (cmp_out),
        .ota_en       (ota_en),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun)
    );

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        hist[cyc] = cmp_out;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic st, input logic rdy, input logic cmp);
        start        = st;
        result_ready = rdy;
        cmp_out      = cmp;
    endtask

    // Majority of the comparator values that reach the sampler for a
    // conversion triggered in cycle t (two synchronizer cycles of delay).
    function automatic logic majority_at(input int t);
        int ones;
        ones = 0;
        for (int j = 0; j < N; j++) begin
            if (hist[t + S - 1 + j] === 1'b1) ones++;
        end
        return (ones > N / 2) ? 1'b1 : 1'b0;
    endfunction

    task automatic checkAll(input string tag, input int k, input logic e_ota, input logic e_busy,
                            input logic e_valid, input logic e_ovr, input bit chk_res, input logic e_res);
        checkOutput($sformatf("%s.ota_en@%0d", tag, k), ota_en, e_ota);
        checkOutput($sformatf("%s.busy@%0d", tag, k), busy, e_busy);
        checkOutput($sformatf("%s.result_valid@%0d", tag, k), result_valid, e_valid);
        checkOutput($sformatf("%s.overrun@%0d", tag, k), overrun, e_ovr);
        if (chk_res) checkOutput($sformatf("%s.result@%0d", tag, k), result, e_res);
    endtask

    // One conversion whose trigger is cycle k=0; k_first=1 continues a
    // conversion chained from the previous handshake cycle.
    task automatic runConversion(input string tag, input int k_first, input int hold_wait,
                                 input int mode, input logic [N-1:0] pattern, input logic outside,
                                 input bit b2b, input int extra_k);
        int   t0;
        int   hs;
        logic cmp_v;
        logic e_res;
        t0 = cyc - k_first;
        hs = S + N + 1 + hold_wait;
        for (int k = k_first; k <= hs; k++) begin
            e_res = (k >= S + N + 1) ? majority_at(t0) : 1'b0;
            checkAll(tag, k, (k >= 1 && k <= S + N), (k >= 1), (k >= S + N + 1),
                     (extra_k >= 0 && k == extra_k + 1), (k >= S + N + 1), e_res);
            if (mode == 0) cmp_v = 1'($urandom);
            else if (k >= S - 1 && k <= S + N - 2) cmp_v = pattern[k - (S - 1)];
            else cmp_v = outside;
            applyStimulus((k == 0) || (k == extra_k) || (b2b && k == hs), (k == hs), cmp_v);
            step();
        end
        start = 1'b0;
    endtask

    task automatic runAuto(input string tag, input int period, input int ncyc, input int off_k,
                           input int t0, input int t1, input int t2, input int ovr_k);
        int   base;
        int   trig [3];
        logic e_ota, e_busy, e_valid, e_res;
        base    = cyc;
        trig[0] = t0;
        trig[1] = t1;
        trig[2] = t2;
        for (int k = 0; k < ncyc; k++) begin
            e_ota   = 1'b0;
            e_busy  = 1'b0;
            e_valid = 1'b0;
            e_res   = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (k >= trig[i] + 1 && k <= trig[i] + S + N) e_ota = 1'b1;
                if (k >= trig[i] + 1 && k <= trig[i] + S + N + 1) e_busy = 1'b1;
                if (k == trig[i] + S + N + 1) begin
                    e_valid = 1'b1;
                    e_res   = majority_at(base + trig[i]);
                end
            end
            checkAll(tag, k, e_ota, e_busy, e_valid, (k == ovr_k), e_valid, e_res);
            auto_en     = (k < off_k);
            auto_period = PER_W'(period);
            applyStimulus(1'b0, 1'b1, 1'($urandom));
            step();
        end
        auto_en = 1'b0;
        step();
        checkOutput($sformatf("%s.busy_after", tag), busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        auto_en      = 1'b0;
        auto_period  = '0;
        cmp_out      = 1'b1;
        result_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            checkAll("reset", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cmp_out = 1'($urandom);
            step();
            checkOutput($sformatf("idle.ota_en@%0d", i), ota_en, 1'b0);
            checkOutput($sformatf("idle.busy@%0d", i), busy, 1'b0);
        end

        runConversion("basic", 0, 0, 1, 5'b11111, 1'b1, 1'b0, -1);
        checkOutput("basic.valid_low", result_valid, 1'b0);

        runConversion("maj10100", 0, 0, 1, 5'b00101, 1'b1, 1'b0, -1);
        runConversion("maj11001", 0, 2, 1, 5'b10011, 1'b0, 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            runConversion($sformatf("rand%0d", r), 0, int'($urandom_range(0, 6)), 0, '0, 1'b0, 1'b0, -1);
        end

        runConversion("ovr_settle", 0, 0, 0, '0, 1'b0, 1'b0, 3);
        runConversion("ovr_hold", 0, 3, 0, '0, 1'b0, 1'b0, S + N + 2);

        runConversion("b2b_a", 0, 6, 0, '0, 1'b0, 1'b1, -1);
        runConversion("b2b_b", 1, 0, 0, '0, 1'b0, 1'b0, -1);

        runAuto("auto20", 20, 70, 70, 19, 39, 59, -1);
        runAuto("auto6", 6, 41, 30, 5, 15, 25, 24);

        for (int k = 0; k < 26; k++) begin
            if (k <= 7) checkAll("abort", k, (k >= 1), (k >= 1), 1'b0, 1'b0, 1'b0, 1'b0);
            else checkAll("abort", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            rst = (k == 7);
            applyStimulus((k == 0), 1'b1, 1'($urandom));
            step();
        end
        rst = 1'b0;
        runConversion("after_abort", 0, 1, 0, '0, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
